// File: rtl/pid_iir.sv
// pid_iir: multi-channel PID/IIR controller that sequences its arithmetic through an external keyed ALU
`ifndef KEY_SIZE
`define KEY_SIZE 4
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 2
`endif
`ifndef ADD
`define ADD 2'd1
`endif
`ifndef SUB
`define SUB 2'd2
`endif
`ifndef MUL
`define MUL 2'd3
`endif
module pid_iir #(
  parameter int NBITS = 16,
  parameter int ORDER = 3,
  parameter int NCH = 2,
  parameter int BASE_KEY = 1,
  parameter int OUT_MIN = -(2 ** (NBITS - 1)),
  parameter int OUT_MAX = 2 ** (NBITS - 1) - 1,
  localparam int NC = NCH * (2 * ORDER + 1),
  localparam int AW = $clog2(NC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [NCH*NBITS-1:0]    sp_i,
  input  logic [NCH*NBITS-1:0]    pv_i,
  output logic [NCH*NBITS-1:0]    co_o,
  output logic [NCH-1:0]          sat_o,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    coef_we,
  input  logic [AW-1:0]           coef_addr,
  input  logic [NBITS-1:0]        coef_data,
  output logic [`KEY_SIZE-1:0]    alu_key_o,
  output logic [`OPCODE_SIZE-1:0] alu_op_o,
  output logic [NBITS-1:0]        alu_A_o,
  output logic [NBITS-1:0]        alu_B_o,
  input  logic [`KEY_SIZE-1:0]    alu_key_i,
  input  logic [NBITS-1:0]        alu_O_i
);
  typedef enum logic [2:0] {IDLE, ERR, MUL, ACC, SAT, DONE} state_t;
  localparam logic [`KEY_SIZE-1:0] K0 = `KEY_SIZE'(BASE_KEY);
  localparam logic [`KEY_SIZE-1:0] K1 = `KEY_SIZE'(BASE_KEY + 1);
  localparam logic signed [NBITS-1:0] OMAX = NBITS'(OUT_MAX);
  localparam logic signed [NBITS-1:0] OMIN = NBITS'(OUT_MIN);
  state_t state_q, state_d;
  logic [3:0] ch_q, ch_d, t_q, t_d;
  logic [NBITS-1:0] acc_q, acc_d, prod_q, prod_d;
  logic [NBITS-1:0] coef_q [NC];
  logic [NBITS-1:0] coef_d [NC];
  logic [NBITS-1:0] eh_q [NCH][ORDER+1];
  logic [NBITS-1:0] eh_d [NCH][ORDER+1];
  logic [NBITS-1:0] uh_q [NCH][ORDER];
  logic [NBITS-1:0] uh_d [NCH][ORDER];
  logic [NBITS-1:0] co_q [NCH];
  logic [NBITS-1:0] co_d [NCH];
  logic [NCH-1:0] sat_q, sat_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [`KEY_SIZE-1:0] key_q, key_d;
  logic [`OPCODE_SIZE-1:0] op_q, op_d;
  logic [NBITS-1:0] a_q, a_d, b_q, b_d;
  logic ok, beta;
  logic [NBITS-1:0] sv, cv, hv;
  int ci, hi;
  assign ok = (key_q != '0) && (alu_key_i == key_q);
  assign sv = ($signed(acc_q) > OMAX) ? OMAX : ($signed(acc_q) < OMIN) ? OMIN : acc_q;
  assign sat_o = sat_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign alu_key_o = key_q;
  assign alu_op_o = op_q;
  assign alu_A_o = a_q;
  assign alu_B_o = b_q;
  genvar g;
  for (g = 0; g < NCH; g++) begin : g_co
    assign co_o[g*NBITS +: NBITS] = co_q[g];
  end
  // Sequencer: term t walks beta_1..beta_ORDER then alpha_ORDER..alpha_0; a new ALU request is latched on every state change
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    t_d = t_q;
    acc_d = acc_q;
    prod_d = prod_q;
    coef_d = coef_q;
    eh_d = eh_q;
    uh_d = uh_q;
    co_d = co_q;
    sat_d = sat_q;
    key_d = key_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    if (coef_we && !busy_q && !clr)
      for (int k = 0; k < NC; k++) if (k == int'(coef_addr)) coef_d[k] = coef_data;
    case (state_q)
      IDLE: if (en) begin
        state_d = ERR;
        ch_d = '0;
      end
      ERR: if (ok) begin
        for (int c = 0; c < NCH; c++) if (c == int'(ch_q)) begin
          for (int k = ORDER; k > 0; k--) eh_d[c][k] = eh_q[c][k-1];
          eh_d[c][0] = alu_O_i;
        end
        acc_d = '0;
        t_d = '0;
        state_d = MUL;
      end
      MUL: if (ok) begin
        prod_d = alu_O_i;
        state_d = ACC;
      end
      ACC: if (ok) begin
        acc_d = alu_O_i;
        t_d = t_q + 4'd1;
        state_d = (int'(t_q) == 2 * ORDER) ? SAT : MUL;
      end
      SAT: begin
        for (int c = 0; c < NCH; c++) if (c == int'(ch_q)) begin
          for (int k = ORDER - 1; k > 0; k--) uh_d[c][k] = uh_q[c][k-1];
          uh_d[c][0] = sv;
          co_d[c] = sv;
          sat_d[c] = sv != acc_q;
        end
        state_d = (int'(ch_q) == NCH - 1) ? DONE : ERR;
        ch_d = (int'(ch_q) == NCH - 1) ? ch_q : ch_q + 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    beta = int'(t_d) < ORDER;
    hi = beta ? int'(t_d) : 2 * ORDER - int'(t_d);
    ci = int'(ch_d) * (2 * ORDER + 1) + (beta ? ORDER + 1 + hi : hi);
    cv = '0;
    hv = '0;
    for (int k = 0; k < NC; k++) if (k == ci) cv = coef_q[k];
    for (int c = 0; c < NCH; c++) if (c == int'(ch_d)) begin
      for (int k = 0; k < ORDER; k++) if (beta && k == hi) hv = uh_d[c][k];
      for (int k = 0; k <= ORDER; k++) if (!beta && k == hi) hv = eh_d[c][k];
    end
    if (state_d != state_q) begin
      key_d = (state_d == ERR) ? K0 : (state_d == MUL || state_d == ACC) ? ((key_q == K0) ? K1 : K0) : '0;
      op_d = (state_d == ERR) ? `SUB : (state_d == MUL) ? `MUL : (state_d == ACC) ? (beta ? `SUB : `ADD) : '0;
      a_d = (state_d == ERR) ? sp_i[int'(ch_d)*NBITS +: NBITS] : (state_d == MUL) ? cv : (state_d == ACC) ? acc_d : '0;
      b_d = (state_d == ERR) ? pv_i[int'(ch_d)*NBITS +: NBITS] : (state_d == MUL) ? hv : (state_d == ACC) ? prod_d : '0;
    end
    if (clr) begin
      state_d = IDLE;
      ch_d = '0;
      t_d = '0;
      acc_d = '0;
      prod_d = '0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k <= ORDER; k++) eh_d[c][k] = '0;
        for (int k = 0; k < ORDER; k++) uh_d[c][k] = '0;
        co_d[c] = '0;
      end
      sat_d = '0;
      key_d = '0;
      op_d = '0;
      a_d = '0;
      b_d = '0;
    end
    busy_d = state_d inside {ERR, MUL, ACC, SAT};
    done_d = state_d == DONE;
  end
  // State register with asynchronous clear of all state, outputs and coefficients
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      t_q <= '0;
      acc_q <= '0;
      prod_q <= '0;
      for (int k = 0; k < NC; k++) coef_q[k] <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k <= ORDER; k++) eh_q[c][k] <= '0;
        for (int k = 0; k < ORDER; k++) uh_q[c][k] <= '0;
        co_q[c] <= '0;
      end
      sat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      key_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      t_q <= t_d;
      acc_q <= acc_d;
      prod_q <= prod_d;
      coef_q <= coef_d;
      eh_q <= eh_d;
      uh_q <= uh_d;
      co_q <= co_d;
      sat_q <= sat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      key_q <= key_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
endmodule

// File: tb/tb_pid_iir.sv
// tb_pid_iir: directed checks of pid_iir (ORDER=1, NCH=2, OUT_MAX=1000) against a 2-cycle-latency ALU responder
`ifndef KEY_SIZE
`define KEY_SIZE 4
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 2
`endif
`ifndef ADD
`define ADD 2'd1
`endif
`ifndef SUB
`define SUB 2'd2
`endif
`ifndef MUL
`define MUL 2'd3
`endif
module tb_pid_iir;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic en = 1'b0;
  logic coef_we = 1'b0;
  logic [2:0] coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic [31:0] sp_i = '0;
  logic [31:0] pv_i = '0;
  logic [31:0] co_o;
  logic [1:0] sat_o;
  logic busy_o, done_o;
  logic [`KEY_SIZE-1:0] alu_key_o;
  logic [`KEY_SIZE-1:0] alu_key_i = '0;
  logic [`OPCODE_SIZE-1:0] alu_op_o;
  logic [15:0] alu_A_o, alu_B_o;
  logic [15:0] alu_O_i = '0;
  logic wrong = 1'b0;
  int lat = 0;
  int n_ops = 0;
  int n_done = 0;
  int n_assert = 0;
  int n_fail = 0;
  pid_iir #(.NBITS(16), .ORDER(1), .NCH(2), .BASE_KEY(1), .OUT_MAX(1000)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .sp_i(sp_i), .pv_i(pv_i),
    .co_o(co_o), .sat_o(sat_o), .busy_o(busy_o), .done_o(done_o),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .alu_key_o(alu_key_o), .alu_op_o(alu_op_o), .alu_A_o(alu_A_o), .alu_B_o(alu_B_o),
    .alu_key_i(alu_key_i), .alu_O_i(alu_O_i)
  );
  always #5 clk = ~clk;
  // ALU: answers each request two falling edges after it appears, or returns a bogus key when told to
  always @(negedge clk) begin
    alu_key_i = '0;
    if (wrong) begin
      alu_key_i = `KEY_SIZE'(3);
      lat = 0;
    end else if (alu_key_o != '0 && rst) begin
      if (lat == 1) begin
        alu_key_i = alu_key_o;
        alu_O_i = (alu_op_o == `ADD) ? 16'(alu_A_o + alu_B_o) : (alu_op_o == `SUB) ? 16'(alu_A_o - alu_B_o) : 16'(alu_A_o * alu_B_o);
        lat = 0;
        n_ops++;
      end else lat++;
    end else lat = 0;
  end
  always @(negedge clk) if (done_o) n_done++;
  task automatic step;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wcoef(input logic [2:0] a, input logic [15:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    step;
    coef_we = 1'b0;
  endtask
  task automatic start;
    n_done = 0;
    n_ops = 0;
    en = 1'b1;
    step;
    en = 1'b0;
  endtask
  task automatic finish;
    int n;
    n = 0;
    while (!done_o && n < 300) begin
      step;
      n++;
    end
    chk("run_timeout", 32'(n < 300), 1);
    step;
  endtask
  task automatic run;
    start;
    finish;
  endtask
  initial begin
    int n;
    step;
    chk("rst_co", co_o, 0);
    chk("rst_sat", 32'(sat_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_key", 32'(alu_key_o), 0);
    rst = 1'b1;
    step;
    wcoef(3'd0, 16'd2);
    sp_i = {16'd5, 16'd100};
    pv_i = {16'd3, 16'd40};
    run;
    chk("p_ch0", 32'(co_o[15:0]), 120);
    chk("p_ch1", 32'(co_o[31:16]), 0);
    chk("p_ops", n_ops, 14);
    chk("p_done", n_done, 1);
    chk("p_busy", 32'(busy_o), 0);
    chk("p_sat", 32'(sat_o), 0);
    wcoef(3'd3, 16'd1);
    wcoef(3'd5, 16'hFFFF);
    sp_i = {16'd10, 16'd100};
    pv_i = {16'd0, 16'd40};
    run;
    chk("int1_ch1", 32'(co_o[31:16]), 10);
    chk("int1_ch0", 32'(co_o[15:0]), 120);
    start;
    chk("int2_hold_ch1", 32'(co_o[31:16]), 10);
    chk("int2_busy", 32'(busy_o), 1);
    finish;
    chk("int2_ch1", 32'(co_o[31:16]), 20);
    start;
    wcoef(3'd0, 16'd50);
    en = 1'b1;
    step;
    en = 1'b0;
    finish;
    chk("int3_ch1", 32'(co_o[31:16]), 30);
    chk("busy_wr_ch0", 32'(co_o[15:0]), 120);
    chk("int3_done", n_done, 1);
    chk("int3_ops", n_ops, 14);
    repeat (3) step;
    chk("en_ignored", 32'(busy_o), 0);
    wcoef(3'd0, 16'd100);
    sp_i = {16'd10, 16'd50};
    pv_i = {16'd0, 16'd0};
    run;
    chk("sat_ch0", 32'(co_o[15:0]), 1000);
    chk("sat_flag", 32'(sat_o), 1);
    chk("sat_ch1", 32'(co_o[31:16]), 40);
    sp_i = {16'd10, 16'd1};
    run;
    chk("unsat_ch0", 32'(co_o[15:0]), 100);
    chk("unsat_flag", 32'(sat_o), 0);
    chk("unsat_ch1", 32'(co_o[31:16]), 50);
    wrong = 1'b1;
    sp_i = {16'd10, 16'd7};
    pv_i = {16'd0, 16'd2};
    start;
    chk("hs_key0", 32'(alu_key_o), 1);
    chk("hs_op0", 32'(alu_op_o), 32'(`SUB));
    chk("hs_a0", 32'(alu_A_o), 7);
    chk("hs_b0", 32'(alu_B_o), 2);
    repeat (5) step;
    chk("hs_key_hold", 32'(alu_key_o), 1);
    chk("hs_a_hold", 32'(alu_A_o), 7);
    chk("hs_b_hold", 32'(alu_B_o), 2);
    chk("hs_busy_hold", 32'(busy_o), 1);
    wrong = 1'b0;
    n = 0;
    while (alu_key_o == `KEY_SIZE'(1) && n < 20) begin
      step;
      n++;
    end
    chk("hs_timeout", 32'(n < 20), 1);
    chk("hs_key_next", 32'(alu_key_o), 2);
    chk("hs_op_next", 32'(alu_op_o), 32'(`MUL));
    chk("hs_a_next", 32'(alu_A_o), 0);
    chk("hs_b_next", 32'(alu_B_o), 100);
    finish;
    chk("hs_ch0", 32'(co_o[15:0]), 500);
    chk("hs_ch1", 32'(co_o[31:16]), 60);
    start;
    n = 0;
    while (alu_op_o != `MUL && n < 20) begin
      step;
      n++;
    end
    chk("clr_timeout", 32'(n < 20), 1);
    clr = 1'b1;
    step;
    clr = 1'b0;
    chk("clr_busy", 32'(busy_o), 0);
    chk("clr_co", co_o, 0);
    chk("clr_key", 32'(alu_key_o), 0);
    step;
    run;
    chk("clr_ch0", 32'(co_o[15:0]), 500);
    chk("clr_ch1", 32'(co_o[31:16]), 10);
    start;
    repeat (6) step;
    rst = 1'b0;
    #1;
    chk("arst_co", co_o, 0);
    chk("arst_key", 32'(alu_key_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_a", 32'(alu_A_o), 0);
    step;
    rst = 1'b1;
    step;
    chk("post_rst_key", 32'(alu_key_o), 0);
    chk("post_rst_busy", 32'(busy_o), 0);
    run;
    chk("post_rst_coef", 32'(co_o[15:0]), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pid_iir.md
PID_IIR -- requirements
Module: pid_iir

Interface
REQ-001 Parameter NBITS, default 16: signed two's-complement data and coefficient width.
REQ-002 Parameter ORDER, default 3: filter order, legal range 1..4.
REQ-003 Parameter NCH, default 2: number of independent control channels, legal range 1..8.
REQ-004 Parameter BASE_KEY, default 1: first ALU key; BASE_KEY and BASE_KEY+1 are nonzero and fit in `KEY_SIZE bits.
REQ-005 Parameters OUT_MIN and OUT_MAX, defaults -2^(NBITS-1) and 2^(NBITS-1)-1: signed output clamp limits, with OUT_MIN <= OUT_MAX.
REQ-006 clk  in  1  single clock; all logic updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 clr  in  1  synchronous clear, active high.
REQ-009 en  in  1  start pulse; sampled only in IDLE.
REQ-010 sp_i  in  NCH*NBITS  setpoints; channel c occupies bits [c*NBITS +: NBITS].
REQ-011 pv_i  in  NCH*NBITS  process values; same packing as sp_i.
REQ-012 co_o  out  NCH*NBITS  control outputs; same packing as sp_i.
REQ-013 sat_o  out  NCH  per-channel flag; high when that channel's last output was clamped.
REQ-014 busy_o  out  1  high from the cycle after en is accepted until DONE.
REQ-015 done_o  out  1  one-cycle pulse when all channels have been updated.
REQ-016 coef_we  in  1  coefficient write strobe.
REQ-017 coef_addr  in  clog2(NCH*(2*ORDER+1))  coefficient address: channel c, index k maps to c*(2*ORDER+1)+k; k=0..ORDER selects alpha_k; k=ORDER+j selects beta_j for j=1..ORDER.
REQ-018 coef_data  in  NBITS  coefficient write data.
REQ-019 alu_key_o  out  `KEY_SIZE  request key; 0 means idle/no request.
REQ-020 alu_op_o  out  `OPCODE_SIZE  operation code: `ADD, `SUB or `MUL.
REQ-021 alu_A_o, alu_B_o  out  NBITS each  ALU operands.
REQ-022 alu_key_i  in  `KEY_SIZE  key of the returned result.
REQ-023 alu_O_i  in  NBITS  ALU result.

Function
REQ-024 Per channel, each run SHALL compute u[n] = sat( sum_{k=0..ORDER} alpha_k*e[n-k] - sum_{j=1..ORDER} beta_j*u[n-j] ), where e[n] = sp - pv; all arithmetic is performed by the external ALU, with NBITS results (wrapping).
REQ-025 Each channel SHALL hold its own e history (ORDER+1 entries) and u history (ORDER entries), initialised to 0.
REQ-026 FSM states SHALL be IDLE, ERR, MUL, ACC, SAT, DONE.
REQ-027 IDLE -> ERR on en; channel index resets to 0; en received while not in IDLE is ignored.
REQ-028 ERR SHALL issue SUB(sp_c, pv_c); when the result returns, e histories shift and e[n] takes the result, and the accumulator clears to 0.
REQ-029 MUL SHALL issue MUL(coef, history) in the order beta_1..beta_ORDER, then alpha_ORDER..alpha_0; ACC SHALL issue SUB(acc, prod) for beta terms and ADD(acc, prod) for alpha terms.
REQ-030 Each channel therefore uses exactly 4*ORDER+3 ALU operations.
REQ-031 A result is accepted when alu_key_i == alu_key_o and alu_key_o != 0; the next request is registered on that same edge.
REQ-032 The request key SHALL alternate BASE_KEY, BASE_KEY+1, ... per operation, starting at BASE_KEY in ERR.
REQ-033 Outputs SHALL hold steady until their result is accepted; there is no timeout.
REQ-034 SAT (one cycle, no ALU request, alu_key_o=0) SHALL clamp acc signed to [OUT_MIN, OUT_MAX], shift the u history, write co_o[c], and set sat_o[c] if clamping occurred, else clear it.
REQ-035 SAT -> ERR for channel c+1 while c < NCH-1; otherwise SAT -> DONE.
REQ-036 DONE pulses done_o for one cycle, then returns to IDLE.
REQ-037 co_o for channels not yet updated in a run SHALL keep their previous values.
REQ-038 Coefficient writes SHALL take effect on the next edge when not busy, and SHALL be ignored while busy_o=1.
REQ-039 clr SHALL take precedence over all activity including en and coef_we: it returns to IDLE and zeroes histories, co_o, sat_o, alu_* outputs and the accumulator; coefficients are retained.
REQ-040 alu_key_o SHALL be 0 in IDLE, SAT and DONE.

Reset
REQ-041 rst low SHALL immediately set: state IDLE; co_o, sat_o, busy_o, done_o and all alu_* outputs 0; histories, accumulator and all coefficients 0.
REQ-042 Matching keys arriving during reset or in IDLE SHALL be ignored.

Verification
REQ-043 Reset: drive rst low mid-run -> all outputs 0 asynchronously; after release, state is IDLE and alu_key_o=0.
REQ-044 P-only: ORDER=1, NCH=2, ALU responds after 2 cycles, ch0 alpha0=2, sp=100, pv=40 -> co_o[ch0]=120 after 7 ALU operations; done_o pulses once after both channels finish.
REQ-045 Integrator: alpha0=1, beta1=0xFFFF (-1), e=10 on three runs -> co_o = 10, 20, 30.
REQ-046 Saturation: OUT_MAX=1000, alpha0=100, e=50 -> co_o=1000 with sat_o=1; next run with e=1 -> sat_o=0.
REQ-047 Handshake: a wrong key returned for 5 cycles -> FSM holds with operands stable; the correct key then advances and the next request uses the alternate key.
REQ-048 clr during MUL -> the next cycle shows busy_o=0, co_o=0 and alu_key_o=0; the coefficients written earlier still produce correct results on the next run.
